// File: rtl/cmp_pkg.sv
// Shared types and cascade resolution for the serial nibble comparator and
// any comparator model that needs the same cascade-input truth table.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef enum logic [1:0] {
        DEC_EQ = 2'd0,
        DEC_GT = 2'd1,
        DEC_LT = 2'd2
    } cmp_dec_t;

    // Result encodings, ordered {agb, alb, aeb}.
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_LT = 3'b010;

    // Resolve an all-equal compare from the cascade inputs.
    // eq dominates; contradictory gt&lt gives 000; no cascade input gives 110.
    function automatic logic [2:0] resolve_cascade(input logic gt,
                                                   input logic lt,
                                                   input logic eq);
        logic [2:0] res;
        if (eq)             res = 3'b001;
        else if (gt && !lt) res = 3'b100;
        else if (!gt && lt) res = 3'b010;
        else if (gt && lt)  res = 3'b000;
        else                res = 3'b110;
        return res;
    endfunction

endpackage

// File: rtl/nibble_cmp4.sv
// Combinational unsigned 4-bit magnitude compare, producing greater/less flags.
// Equality is implied when both flags are low.
module nibble_cmp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/serial_nibble_comparator.sv
// Multi-cycle wide magnitude comparator: scans one nibble per clock, MSB first,
// and registers agb/alb/aeb with a start/busy/done handshake. An all-equal scan
// falls back to the latched cascade inputs, so this stage can feed a 4-bit
// cascadable comparator or another instance of itself.
//
// Build option: define SNC_EARLY_EXIT_EN to finish as soon as the first
// differing nibble decides the result (latency 2..NIBBLES+1 cycles). Without it
// every nibble is scanned and latency is fixed at NIBBLES+1 cycles.
module serial_nibble_comparator
    import cmp_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    input  logic                   cas_gt,
    input  logic                   cas_lt,
    input  logic                   cas_eq,
    output logic                   busy,
    output logic                   done,
    output logic                   agb,
    output logic                   alb,
    output logic                   aeb
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    cmp_state_t        state_q, state_d;
    cmp_dec_t          dec_q,   dec_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [W-1:0]      a_q,     a_d;
    logic [W-1:0]      b_q,     b_d;
    logic [2:0]        cas_q,   cas_d;   // {gt, lt, eq}
    logic [2:0]        res_q,   res_d;   // {agb, alb, aeb}

    logic [3:0]        a_nib, b_nib;
    logic              nib_gt, nib_lt;
    cmp_dec_t          dec_scan;
    logic              scan_last;

    // Single shared nibble comparator; the mux walks it across the operands.
    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];

    nibble_cmp4 u_nibble_cmp4 (
        .a  (a_nib),
        .b  (b_nib),
        .gt (nib_gt),
        .lt (nib_lt)
    );

    // Next-state, decision update and result capture.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d   = state_q;
        dec_d     = dec_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        cas_d     = cas_q;
        res_d     = res_q;
        scan_last = 1'b0;

        // The first differing nibble from the MSB end wins; later ones are ignored.
        dec_scan = dec_q;
        if (dec_q == DEC_EQ) begin
            if (nib_gt)      dec_scan = DEC_GT;
            else if (nib_lt) dec_scan = DEC_LT;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    cas_d   = {cas_gt, cas_lt, cas_eq};
                    idx_d   = IDX_W'(NIBBLES - 1);
                    dec_d   = DEC_EQ;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                dec_d     = dec_scan;
                scan_last = (idx_q == '0);
`ifdef SNC_EARLY_EXIT_EN
                if (dec_q == DEC_EQ && dec_scan != DEC_EQ) scan_last = 1'b1;
`endif
                if (!scan_last) idx_d = idx_q - 1'b1;
                if (scan_last) begin
                    state_d = DONE;
                    case (dec_scan)
                        DEC_GT:  res_d = RES_GT;
                        DEC_LT:  res_d = RES_LT;
                        default: res_d = resolve_cascade(cas_q[2], cas_q[1], cas_q[0]);
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dec_q   <= DEC_EQ;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cas_q   <= '0;
            res_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q <= state_d;
            dec_q   <= dec_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cas_q   <= cas_d;
            res_q   <= res_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign {agb, alb, aeb} = res_q;

endmodule

// File: tb/tb_serial_nibble_comparator.sv
// Self-checking bench for serial_nibble_comparator (NIBBLES = 4).
// Expected results and latencies are queued when a compare is presented and
// popped when done pulses.
module tb_serial_nibble_comparator;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in, b_in;
    logic        cas_gt, cas_lt, cas_eq;
    logic        busy, done, agb, alb, aeb;

    typedef struct {
        logic [2:0] res;
        int         lat;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   fails   = 0;

    serial_nibble_comparator #(.NIBBLES(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .cas_gt (cas_gt),
        .cas_lt (cas_lt),
        .cas_eq (cas_eq),
        .busy   (busy),
        .done   (done),
        .agb    (agb),
        .alb    (alb),
        .aeb    (aeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result: full-width unsigned compare, cascade table on equality.
    function automatic logic [2:0] model_res(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [2:0]  cas);
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        case (cas)
            3'b001, 3'b011, 3'b101, 3'b111: return 3'b001;
            3'b100:                         return 3'b100;
            3'b010:                         return 3'b010;
            3'b110:                         return 3'b000;
            default:                        return 3'b110;
        endcase
    endfunction

    // Edges from the accepting edge (counted as 1) to the first done sample.
    function automatic int model_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef SNC_EARLY_EXIT_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (a[i*4 +: 4] != b[i*4 +: 4]) return N - i + 1;
        end
`endif
        return N + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] cas, input string tag);
        exp_t e;
        e.res = model_res(a, b, cas);
        e.lat = model_lat(a, b);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the current outputs.
    task automatic pop_and_check(input int cyc);
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            fails++;
            $error("FAIL sb_empty: observed done with no pending compare, expected none");
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_res"}, {29'd0, agb, alb, aeb}, {29'd0, e.res});
            check({e.tag, "_lat"}, cyc, e.lat);
        end
    endtask

    // One isolated compare; inputs are scrambled after acceptance to prove latching.
    task automatic do_compare(input logic [15:0] a, input logic [15:0] b,
                              input logic [2:0] cas, input string tag);
        int   cyc;
        logic got;
        logic [2:0] res_seen;
        @(negedge clk);
        a_in = a;
        b_in = b;
        {cas_gt, cas_lt, cas_eq} = cas;
        start = 1'b1;
        push_exp(a, b, cas, tag);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                a_in  = ~a;
                b_in  = ~b;
                {cas_gt, cas_lt, cas_eq} = ~cas;
                check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            end
            if (done) begin
                got = 1'b1;
                check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
                res_seen = {agb, alb, aeb};
                pop_and_check(cyc);
            end
        end
        if (!got) check({tag, "_timeout"}, {31'd0, done}, 32'd1);
        else begin
            @(posedge clk);
            #1;
            check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
            check({tag, "_hold"}, {29'd0, agb, alb, aeb}, {29'd0, res_seen});
        end
    endtask

    logic [15:0] ha [3];
    logic [15:0] hb [3];

    initial begin
        int nxt, cyc, ndone, guard;
        logic [2:0] sweep_cas [5];

        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        {cas_gt, cas_lt, cas_eq} = 3'b000;

        // Reset state
        #2;
        check("reset_outputs", {27'd0, busy, done, agb, alb, aeb}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_outputs", {27'd0, busy, done, agb, alb, aeb}, 32'd0);

        // Directed compares
        do_compare(16'hF000, 16'h0FFF, 3'b001, "msb_differs");
        do_compare(16'h1234, 16'h1235, 3'b001, "lsb_differs");
        do_compare(16'h1334, 16'h1243, 3'b010, "mid_differs");
        do_compare(16'hFFFF, 16'h0000, 3'b000, "max_vs_min");
        do_compare(16'h0000, 16'hFFFF, 3'b100, "min_vs_max");

        // Reset during the second RUN cycle: everything clears, no done.
        @(negedge clk);
        a_in  = 16'h1234;
        b_in  = 16'h1235;
        {cas_gt, cas_lt, cas_eq} = 3'b001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {27'd0, busy, done, agb, alb, aeb}, 32'd0);
        @(posedge clk);
        #1;
        check("in_reset_outputs", {27'd0, busy, done, agb, alb, aeb}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_no_done", {30'd0, busy, done}, 32'd0);
        end
        do_compare(16'h1234, 16'h1235, 3'b001, "after_reset");

        // Equal operands, cascade sweep
        sweep_cas[0] = 3'b100;
        sweep_cas[1] = 3'b010;
        sweep_cas[2] = 3'b001;
        sweep_cas[3] = 3'b110;
        sweep_cas[4] = 3'b000;
        for (int i = 0; i < 5; i++) begin
            do_compare(16'hA5A5, 16'hA5A5, sweep_cas[i], $sformatf("cas_sweep%0d", i));
        end

        // Handshake: start held high, next operands presented during RUN.
        ha[0] = 16'h8000; hb[0] = 16'h7FFF;
        ha[1] = 16'h0001; hb[1] = 16'h0002;
        ha[2] = 16'h5A5A; hb[2] = 16'h5A5A;
        @(negedge clk);
        a_in  = ha[0];
        b_in  = hb[0];
        {cas_gt, cas_lt, cas_eq} = 3'b001;
        start = 1'b1;
        push_exp(ha[0], hb[0], 3'b001, "b2b0");
        nxt   = 1;
        cyc   = 0;
        ndone = 0;
        guard = 0;
        while (ndone < 3 && guard < 60) begin
            @(posedge clk);
            #1;
            guard++;
            cyc++;
            if (cyc == 1) begin
                if (nxt < 3) begin
                    a_in = ha[nxt];
                    b_in = hb[nxt];
                    push_exp(ha[nxt], hb[nxt], 3'b001, $sformatf("b2b%0d", nxt));
                    nxt++;
                end else begin
                    start = 1'b0;
                    a_in  = 16'hDEAD;
                    b_in  = 16'hBEEF;
                end
            end
            if (done) begin
                check("b2b_busy_in_done", {31'd0, busy}, 32'd0);
                pop_and_check(cyc);
                ndone++;
                cyc = 0;
            end else begin
                check("b2b_busy_in_run", {31'd0, busy}, 32'd1);
            end
        end
        if (ndone < 3) check("b2b_timeout", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        check("b2b_idle", {30'd0, busy, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
